// File: rtl/display_frame_arbiter.sv
// Round-robin arbiter that latches one requester's 8x8 frame into a back buffer and
// swaps it to the front buffer on a scan-start pulse once the minimum dwell has elapsed.
module display_frame_arbiter #(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned DWELL_FRAMES = 4,
    parameter int unsigned IDX_W        = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [64*N_REQ-1:0]   FRAMES,
    output logic [N_REQ-1:0]      GNT,
    input  logic                  FRAME_SYNC,
    output logic [63:0]           DATA,
    output logic [IDX_W-1:0]      OWNER,
    output logic                  OWNER_VALID,
    output logic                  SWAP
);

    localparam int unsigned CNT_W = $clog2(DWELL_FRAMES + 1);
    localparam int unsigned PAD_W = 2 ** IDX_W;

    logic                 back_valid_q;
    logic [63:0]          back_buf_q;
    logic [IDX_W-1:0]     back_owner_q;
    logic [IDX_W-1:0]     rr_last_q;
    logic [CNT_W-1:0]     dwell_cnt_q;

    logic [PAD_W-1:0]     req_pad;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [63:0]          grant_frame;
    logic                 do_grant;
    logic                 do_swap;

    // Pad REQ to a power of two so it can be indexed directly by an IDX_W-bit index.
    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = REQ;
    end

    // First set request after the last winner, wrapping modulo N_REQ.
    always_comb begin : rr_pick
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = int'(rr_last_q) + k;
            if (cand >= int'(N_REQ)) begin
                cand = cand - int'(N_REQ);
            end
            if (!grant_found && req_pad[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        grant_frame = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_idx == IDX_W'(i)) begin
                grant_frame = FRAMES[64*i +: 64];
            end
        end
    end

    assign do_grant = !back_valid_q && grant_found;
    assign do_swap  = FRAME_SYNC && back_valid_q &&
                      (int'(dwell_cnt_q) + 1 >= int'(DWELL_FRAMES));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            back_valid_q <= 1'b0;
            back_buf_q   <= '0;
            back_owner_q <= '0;
            rr_last_q    <= IDX_W'(N_REQ - 1);
            dwell_cnt_q  <= CNT_W'(DWELL_FRAMES);
            GNT          <= '0;
            DATA         <= '0;
            OWNER        <= '0;
            OWNER_VALID  <= 1'b0;
            SWAP         <= 1'b0;
        end else begin
            GNT  <= '0;
            SWAP <= do_swap;
            if (do_grant) begin
                back_buf_q   <= grant_frame;
                back_owner_q <= grant_idx;
                rr_last_q    <= grant_idx;
                back_valid_q <= 1'b1;
                GNT          <= N_REQ'(1) << grant_idx;
            end
            // Grant needs an empty back buffer and swap a full one, so they never collide.
            if (do_swap) begin
                DATA         <= back_buf_q;
                OWNER        <= back_owner_q;
                OWNER_VALID  <= 1'b1;
                back_valid_q <= 1'b0;
                dwell_cnt_q  <= '0;
            end else if (FRAME_SYNC && (int'(dwell_cnt_q) < int'(DWELL_FRAMES))) begin
                dwell_cnt_q <= dwell_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_frame_arbiter.sv
// Bench for display_frame_arbiter: directed scenarios on a 2-source/dwell-4 instance and
// round-robin plus randomized model comparison on a 3-source/dwell-1 instance.
module tb_display_frame_arbiter;

    localparam int RN = 3;
    localparam int RD = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]   req_a;
    logic [127:0] frames_a;
    logic         sync_a;
    logic [1:0]   gnt_a;
    logic [63:0]  data_a;
    logic [2:0]   owner_a;
    logic         ovalid_a;
    logic         swap_a;

    logic [2:0]   req_b;
    logic [191:0] frames_b;
    logic         sync_b;
    logic [2:0]   gnt_b;
    logic [63:0]  data_b;
    logic [1:0]   owner_b;
    logic         ovalid_b;
    logic         swap_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    display_frame_arbiter #(.N_REQ(2), .DWELL_FRAMES(4), .IDX_W(3)) dut_a (
        .CLK(clk), .RST(rst), .REQ(req_a), .FRAMES(frames_a), .GNT(gnt_a),
        .FRAME_SYNC(sync_a), .DATA(data_a), .OWNER(owner_a), .OWNER_VALID(ovalid_a),
        .SWAP(swap_a)
    );

    display_frame_arbiter #(.N_REQ(RN), .DWELL_FRAMES(RD), .IDX_W(2)) dut_b (
        .CLK(clk), .RST(rst), .REQ(req_b), .FRAMES(frames_b), .GNT(gnt_b),
        .FRAME_SYNC(sync_b), .DATA(data_b), .OWNER(owner_b), .OWNER_VALID(ovalid_b),
        .SWAP(swap_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync_a();
        sync_a = 1'b1;
        step();
        sync_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        req_a = 2'b01;
        frames_a[63:0] = 64'h55;
        step();
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (gnt_a !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt_a);
        else n_pass++;
        n_checks++;
        if (data_a !== 64'h0 || ovalid_a !== 1'b0 || swap_a !== 1'b0 || owner_a !== 3'd0)
            $display("FAIL reset_outs: data=%h ov=%b swap=%b owner=%0d want 0/0/0/0",
                     data_a, ovalid_a, swap_a, owner_a);
        else n_pass++;
        req_a = 2'b00;
        #2 rst = 1'b0;
        step();
        for (int s = 0; s < 3; s++) begin
            pulse_sync_a();
            n_checks++;
            if (swap_a !== 1'b0 || data_a !== 64'h0)
                $display("FAIL reset_idle_sync%0d: swap=%b data=%h want 0/0", s, swap_a, data_a);
            else n_pass++;
            repeat (2) step();
        end
    endtask

    task automatic test_single_source();
        req_a = 2'b01;
        frames_a[63:0] = 64'hDEADBEEF_01234567;
        step();
        n_checks++;
        if (gnt_a !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt_a);
        else n_pass++;
        req_a = 2'b00;
        step();
        n_checks++;
        if (gnt_a !== 2'b00) $display("FAIL single_gnt_pulse: got %b want 00", gnt_a);
        else n_pass++;
        pulse_sync_a();
        n_checks++;
        if (swap_a !== 1'b1 || data_a !== 64'hDEADBEEF_01234567 || owner_a !== 3'd0 ||
            ovalid_a !== 1'b1)
            $display("FAIL single_swap: swap=%b data=%h owner=%0d ov=%b want 1/deadbeef01234567/0/1",
                     swap_a, data_a, owner_a, ovalid_a);
        else n_pass++;
        step();
        n_checks++;
        if (swap_a !== 1'b0) $display("FAIL single_swap_pulse: got %b want 0", swap_a);
        else n_pass++;
        req_a = 2'b01;
        frames_a[63:0] = 64'h1;
        step();
        n_checks++;
        if (gnt_a !== 2'b01) $display("FAIL single_regnt: got %b want 01", gnt_a);
        else n_pass++;
        req_a = 2'b00;
        for (int s = 1; s <= 3; s++) begin
            repeat (3) step();
            pulse_sync_a();
            n_checks++;
            if (swap_a !== 1'b0 || data_a !== 64'hDEADBEEF_01234567)
                $display("FAIL dwell_sync%0d: swap=%b data=%h want 0/deadbeef01234567",
                         s, swap_a, data_a);
            else n_pass++;
        end
        repeat (3) step();
        pulse_sync_a();
        n_checks++;
        if (swap_a !== 1'b1 || data_a !== 64'h1)
            $display("FAIL dwell_sync4: swap=%b data=%h want 1/1", swap_a, data_a);
        else n_pass++;
    endtask

    task automatic test_sync_gating();
        logic bad;
        for (int s = 0; s < 3; s++) begin
            repeat (2) step();
            pulse_sync_a();
        end
        repeat (2) step();
        req_a = 2'b10;
        frames_a[127:64] = 64'hCAFE_F00D_1234_5678;
        step();
        n_checks++;
        if (gnt_a !== 2'b10) $display("FAIL gating_gnt: got %b want 10", gnt_a);
        else n_pass++;
        req_a = 2'b00;
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (swap_a !== 1'b0 || data_a !== 64'h1) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL gating_hold: swap=%b data=%h want 0/1 between syncs", swap_a, data_a);
        else n_pass++;
        pulse_sync_a();
        n_checks++;
        if (swap_a !== 1'b1 || data_a !== 64'hCAFE_F00D_1234_5678 || owner_a !== 3'd1)
            $display("FAIL gating_swap: swap=%b data=%h owner=%0d want 1/cafef00d12345678/1",
                     swap_a, data_a, owner_a);
        else n_pass++;
    endtask

    task automatic test_withdrawn();
        logic seen;
        req_a = 2'b01;
        frames_a[63:0] = 64'h0BAD_C0DE_0000_0042;
        step();
        n_checks++;
        if (gnt_a !== 2'b01) $display("FAIL withdrawn_load: got %b want 01", gnt_a);
        else n_pass++;
        req_a = 2'b00;
        step();
        req_a = 2'b10;
        frames_a[127:64] = 64'h7777;
        step();
        req_a = 2'b00;
        seen = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                if (gnt_a[1] !== 1'b0) seen = 1'b1;
            end
            pulse_sync_a();
            if (gnt_a[1] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL withdrawn_nognt: got gnt[1]=1 want never");
        else n_pass++;
        n_checks++;
        if (swap_a !== 1'b1 || owner_a !== 3'd0 || data_a !== 64'h0BAD_C0DE_0000_0042)
            $display("FAIL withdrawn_swap: swap=%b owner=%0d data=%h want 1/0/0badc0de00000042",
                     swap_a, owner_a, data_a);
        else n_pass++;
        req_a = 2'b10;
        frames_a[127:64] = 64'h8888;
        step();
        n_checks++;
        if (gnt_a !== 2'b10) $display("FAIL withdrawn_regnt: got %b want 10", gnt_a);
        else n_pass++;
        req_a = 2'b00;
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 2; s++) begin
            step();
            pulse_sync_a();
        end
        n_checks++;
        if (swap_a !== 1'b0 || data_a !== 64'h0BAD_C0DE_0000_0042)
            $display("FAIL midreset_pre: swap=%b data=%h want 0/0badc0de00000042", swap_a, data_a);
        else n_pass++;
        step();
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (data_a !== 64'h0 || ovalid_a !== 1'b0 || owner_a !== 3'd0)
            $display("FAIL midreset_outs: data=%h ov=%b owner=%0d want 0/0/0",
                     data_a, ovalid_a, owner_a);
        else n_pass++;
        #2 rst = 1'b0;
        step();
        pulse_sync_a();
        n_checks++;
        if (swap_a !== 1'b0 || data_a !== 64'h0)
            $display("FAIL midreset_empty: swap=%b data=%h want 0/0", swap_a, data_a);
        else n_pass++;
        repeat (2) step();
        req_a = 2'b11;
        step();
        n_checks++;
        if (gnt_a !== 2'b01) $display("FAIL midreset_rrstart: got %b want 01", gnt_a);
        else n_pass++;
        req_a = 2'b00;
    endtask

    task automatic test_round_robin();
        int gq[$];
        int sq[$];
        logic data_bad;
        int exp_seq[4];
        exp_seq = '{0, 1, 0, 1};
        data_bad = 1'b0;
        for (int i = 0; i < RN; i++) frames_b[64*i +: 64] = 64'hA0 + 64'(i);
        req_b = 3'b011;
        for (int c = 1; c <= 85; c++) begin
            sync_b = (c % 20 == 0);
            step();
            for (int i = 0; i < RN; i++) if (gnt_b[i] === 1'b1) gq.push_back(i);
            if (swap_b === 1'b1) begin
                sq.push_back(int'(owner_b));
                if (data_b !== 64'hA0 + 64'(owner_b)) data_bad = 1'b1;
            end
        end
        sync_b = 1'b0;
        req_b = 3'b000;
        n_checks++;
        if (gq.size() < 4 || sq.size() < 4)
            $display("FAIL rr_counts: grants=%0d swaps=%0d want >=4 each", gq.size(), sq.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) begin
                n_checks++;
                if (gq[k] !== exp_seq[k])
                    $display("FAIL rr_grant%0d: got %0d want %0d", k, gq[k], exp_seq[k]);
                else n_pass++;
            end
            if (k < sq.size()) begin
                n_checks++;
                if (sq[k] !== exp_seq[k])
                    $display("FAIL rr_owner%0d: got %0d want %0d", k, sq[k], exp_seq[k]);
                else n_pass++;
            end
        end
        n_checks++;
        if (data_bad) $display("FAIL rr_data: swapped DATA not the owner's frame");
        else n_pass++;
    endtask

    task automatic test_random();
        logic        m_full;
        logic [63:0] m_back;
        int          m_bown;
        int          m_last;
        int          m_dwell;
        logic [63:0] m_front;
        int          m_own;
        logic        m_ov;
        logic [2:0]  m_gnt;
        logic        m_swap;
        logic        do_swap;
        logic        found;
        int          w;
        req_b = 3'b000;
        sync_b = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_full = 1'b0; m_back = '0; m_bown = 0; m_last = RN - 1; m_dwell = RD;
        m_front = '0; m_own = 0; m_ov = 1'b0; m_gnt = '0; m_swap = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            // Requesters hold REQ and frame until granted, with occasional withdrawals.
            for (int i = 0; i < RN; i++) begin
                if (req_b[i] && m_gnt[i]) begin
                    req_b[i] = 1'($urandom_range(0, 1));
                    frames_b[64*i +: 64] = {$urandom, $urandom};
                end else if (!req_b[i] && $urandom_range(0, 3) == 0) begin
                    req_b[i] = 1'b1;
                    frames_b[64*i +: 64] = {$urandom, $urandom};
                end else if (req_b[i] && $urandom_range(0, 15) == 0) begin
                    req_b[i] = 1'b0;
                end
            end
            sync_b = ($urandom_range(0, 5) == 0);
            do_swap = sync_b && m_full && (m_dwell + 1 >= RD);
            found = 1'b0;
            w = 0;
            if (!m_full) begin
                for (int d = 1; d <= RN; d++) begin
                    if (!found && req_b[(m_last + d) % RN]) begin
                        found = 1'b1;
                        w = (m_last + d) % RN;
                    end
                end
            end
            m_swap = do_swap;
            if (do_swap) begin
                m_front = m_back; m_own = m_bown; m_ov = 1'b1; m_full = 1'b0; m_dwell = 0;
            end else if (sync_b && m_dwell < RD) begin
                m_dwell = m_dwell + 1;
            end
            m_gnt = '0;
            if (found) begin
                m_back = frames_b[64*w +: 64]; m_bown = w; m_last = w; m_full = 1'b1;
                m_gnt[w] = 1'b1;
            end
            step();
            n_checks++;
            if (gnt_b !== m_gnt || swap_b !== m_swap || ovalid_b !== m_ov ||
                owner_b !== 2'(m_own) || data_b !== m_front)
                $display("FAIL random_c%0d: gnt=%b swap=%b ov=%b owner=%0d data=%h want %b/%b/%b/%0d/%h",
                         c, gnt_b, swap_b, ovalid_b, owner_b, data_b,
                         m_gnt, m_swap, m_ov, m_own, m_front);
            else n_pass++;
        end
        req_b = 3'b000;
        sync_b = 1'b0;
    endtask

    initial begin
        req_a = '0; frames_a = '0; sync_a = 1'b0;
        req_b = '0; frames_b = '0; sync_b = 1'b0;
        test_reset();
        test_single_source();
        test_sync_gating();
        test_withdrawn();
        test_reset_mid();
        test_round_robin();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
